freq_gate_counter: RTL
======================

FREQ_GATE_COUNTER -- requirements
Module: freq_gate_counter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of both event counters and the divider operands.
REQ-002 SHALL have parameter GATE_CYCLES, default 1000, the nominal gate length in clk cycles (>=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, the maximum clk cycles spent waiting for a signal edge.
REQ-004 SHALL have input clk (1 bit), the reference clock; all logic is rising-edge.
REQ-005 SHALL have input rst_n (1 bit), the asynchronous active-low reset.
REQ-006 SHALL have input sig_in (1 bit), the measured signal, asynchronous to clk.
REQ-007 SHALL have input start (1 bit), a one-cycle measurement request.
REQ-008 SHALL have input div_ready (1 bit), high while the downstream divider is idle.
REQ-009 SHALL have input div_vld (1 bit), the divider result-valid pulse.
REQ-010 SHALL have output div_en (1 bit), the divider start request.
REQ-011 SHALL have outputs dividend and divisor (CNT_WIDTH each), carrying the reference count and signal count respectively.
REQ-012 SHALL have outputs busy, done, timeout and ovf (1 bit each).

Function
REQ-013 SHALL synchronise sig_in through 2 flops plus 1 history flop; a rising edge (edge_p) is sync==1 and history==0, one cycle long.
REQ-014 SHALL implement the states IDLE, ARM, GATE, CLOSE, REQ, WAIT and DONE.
- IDLE->ARM on start.
- ARM->GATE on edge_p.
- GATE->CLOSE after exactly GATE_CYCLES cycles in GATE.
- CLOSE->REQ on edge_p.
- REQ->WAIT when div_en and div_ready are both 1.
- WAIT->DONE on div_vld.
- DONE->IDLE unconditionally.
REQ-015 SHALL clear cnt_ref, cnt_sig, the gate timer, the wait timer, timeout and ovf in the ARM cycle that sees edge_p (the opening edge).
REQ-016 SHALL increment cnt_ref every cycle in GATE and CLOSE, including the cycle of the closing edge.
REQ-017 SHALL increment cnt_sig on every edge_p in GATE and CLOSE, including the closing edge, so that cnt_sig equals the number of whole signal periods.
REQ-018 SHALL load dividend=cnt_ref and divisor=cnt_sig, including the closing-edge increments, on the CLOSE->REQ transition, and SHALL hold them until the next such transition; divisor is therefore never 0.
REQ-019 SHALL drive div_en=1 only in REQ; the handshake completes in the cycle div_en and div_ready are both 1, and a REQ held with div_ready=0 waits indefinitely.
REQ-020 SHALL pulse done for exactly one cycle in DONE.
REQ-021 SHALL drive busy=1 in every state except IDLE.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL, if ARM or CLOSE waits TIMEOUT_CYCLES cycles without edge_p, set timeout=1 and go directly to DONE with no divider request; timeout holds until the next opening edge or reset.
REQ-024 SHALL ignore div_vld outside WAIT.

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-measurement, force state IDLE and drive all outputs, counters and timers to 0 without waiting for a clk edge.
REQ-026 SHALL, after reset release, start no measurement until a new start pulse.

Configuration
REQ-027 SHALL, with macro FGC_OVF_SAT_EN defined, saturate cnt_ref and cnt_sig at all-ones and set ovf=1 until the next opening edge; the divider is still requested with the saturated values.
REQ-028 SHALL, with FGC_OVF_SAT_EN undefined, let the counters wrap modulo 2^CNT_WIDTH and tie ovf to constant 0.

Verification
REQ-029 SHALL cover: CNT_WIDTH=16, GATE_CYCLES=100, sig_in period 10 clk, start -> div_en with dividend=110 and divisor=11; divider model returns div_vld -> one done pulse, busy drops the following cycle.
REQ-030 SHALL cover: sig_in held 0, TIMEOUT_CYCLES=50, start -> timeout=1, done pulse ~50 cycles after ARM entry, div_en never asserted.
REQ-031 SHALL cover: div_ready held 0 for 20 cycles in REQ -> div_en stays 1 with dividend and divisor stable; div_ready=1 -> WAIT entered the next cycle.
REQ-032 SHALL cover: rst_n asserted in the middle of GATE -> all outputs 0 immediately; after release, no activity without start.
REQ-033 SHALL cover: CNT_WIDTH=6, GATE_CYCLES=100, macro defined -> dividend=63 and ovf=1; macro undefined -> dividend=110 mod 64=46 and ovf=0.
REQ-034 SHALL cover: start pulsed during GATE -> no effect, and the counts are identical to an undisturbed run.

Source files
------------

// File: rtl/freq_gate_counter.sv
// Reciprocal frequency counter: gates on whole sig_in periods, hands ref/sig counts to a divider.
// Build option: FGC_OVF_SAT_EN saturates the event counters and reports ovf; otherwise they wrap.
module freq_gate_counter #(
  parameter int CNT_WIDTH      = 16,
  parameter int GATE_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic                 div_ready,
  input  logic                 div_vld,
  output logic                 div_en,
  output logic [CNT_WIDTH-1:0] dividend,
  output logic [CNT_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 ovf
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARM, GATE, CLOSE, REQ, WAIT, DONE} state_e;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] dividend;
    logic [CNT_WIDTH-1:0] divisor;
  } div_req_t;

  state_e               state_q;
  logic [2:0]           sync_q;
  logic [CNT_WIDTH-1:0] cnt_ref_q, cnt_sig_q;
  logic [CNT_WIDTH-1:0] cnt_ref_d, cnt_sig_d;
  logic [GW-1:0]        gate_tmr_q;
  logic [TW-1:0]        wait_tmr_q;
  div_req_t             req_q;
  logic                 div_en_q, busy_q, done_q, timeout_q;
  logic                 edge_p, gate_last, wait_last;

  // sync_q[1:0] is the 2-flop synchroniser, sync_q[2] the history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], sig_in};
  end

  assign edge_p    = sync_q[1] & ~sync_q[2];
  assign gate_last = (gate_tmr_q == GW'(GATE_CYCLES - 1));
  assign wait_last = (wait_tmr_q == TW'(TIMEOUT_CYCLES - 1));

`ifdef FGC_OVF_SAT_EN
  logic ovf_q, ref_sat, sig_sat, ovf_hit;
  assign ref_sat   = &cnt_ref_q;
  assign sig_sat   = &cnt_sig_q;
  assign cnt_ref_d = ref_sat ? cnt_ref_q : cnt_ref_q + 1'b1;
  assign cnt_sig_d = sig_sat ? cnt_sig_q : cnt_sig_q + 1'b1;
  assign ovf_hit   = ref_sat | (edge_p & sig_sat);
  assign ovf       = ovf_q;
`else
  assign cnt_ref_d = cnt_ref_q + 1'b1;
  assign cnt_sig_d = cnt_sig_q + 1'b1;
  assign ovf       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_ref_q  <= '0;
      cnt_sig_q  <= '0;
      gate_tmr_q <= '0;
      wait_tmr_q <= '0;
      req_q      <= '0;
      div_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef FGC_OVF_SAT_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q    <= ARM;
          busy_q     <= 1'b1;
          wait_tmr_q <= '0;
        end
        ARM: begin
          if (edge_p) begin
            // opening edge: fresh measurement window
            state_q    <= GATE;
            cnt_ref_q  <= '0;
            cnt_sig_q  <= '0;
            gate_tmr_q <= '0;
            wait_tmr_q <= '0;
            timeout_q  <= 1'b0;
`ifdef FGC_OVF_SAT_EN
            ovf_q      <= 1'b0;
`endif
          end else if (wait_last) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            wait_tmr_q <= wait_tmr_q + 1'b1;
          end
        end
        GATE: begin
          cnt_ref_q <= cnt_ref_d;
          if (edge_p) cnt_sig_q <= cnt_sig_d;
`ifdef FGC_OVF_SAT_EN
          if (ovf_hit) ovf_q <= 1'b1;
`endif
          if (gate_last) begin
            state_q    <= CLOSE;
            wait_tmr_q <= '0;
          end else begin
            gate_tmr_q <= gate_tmr_q + 1'b1;
          end
        end
        CLOSE: begin
          cnt_ref_q <= cnt_ref_d;
`ifdef FGC_OVF_SAT_EN
          if (ovf_hit) ovf_q <= 1'b1;
`endif
          if (edge_p) begin
            // closing edge counts toward both totals before they are latched
            cnt_sig_q      <= cnt_sig_d;
            req_q.dividend <= cnt_ref_d;
            req_q.divisor  <= cnt_sig_d;
            div_en_q       <= 1'b1;
            state_q        <= REQ;
          end else if (wait_last) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            wait_tmr_q <= wait_tmr_q + 1'b1;
          end
        end
        REQ: if (div_en_q && div_ready) begin
          div_en_q <= 1'b0;
          state_q  <= WAIT;
        end
        WAIT: if (div_vld) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_en   = div_en_q;
  assign dividend = req_q.dividend;
  assign divisor  = req_q.divisor;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;

endmodule
